// File: rtl/ex_mul_div_unit_if.sv
// EX-stage mul/div bus: instruction request in, stall/result out.
interface ex_mul_div_unit_if #(
  parameter int XLEN = 64
);
  logic            valid_i;
  logic [2:0]      op_i;
  logic            word_i;
  logic [XLEN-1:0] src1_i;
  logic [XLEN-1:0] src2_i;
  logic            ex_hold_i;
  logic            flush_i;
  logic            stall_o;
  logic [XLEN-1:0] result_o;
  logic            result_valid_o;
  logic            busy_o;

  modport master (
    output valid_i, op_i, word_i, src1_i, src2_i, ex_hold_i, flush_i,
    input  stall_o, result_o, result_valid_o, busy_o
  );

  modport slave (
    input  valid_i, op_i, word_i, src1_i, src2_i, ex_hold_i, flush_i,
    output stall_o, result_o, result_valid_o, busy_o
  );
endinterface

// File: rtl/ex_mul_div_unit.sv
// Iterative RV64M multiply/divide unit: shift-add multiply, restoring divide,
// one bit per cycle on unsigned magnitudes with sign fix-up on completion.
module ex_mul_div_unit #(
  parameter int XLEN         = 64,
  parameter bit FAST_SPECIAL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  ex_mul_div_unit_if.slave bus
);
  localparam int CW = $clog2(XLEN + 1);
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_CALC = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d, res_q, res_d;
  logic [2:0]      op_q, op_d;
  logic            word_q, word_d, neg_q, neg_d;

  logic            is_div, wd, s1s, s2s, n1, n2, div0, ovf, start, neg_f;
  logic [XLEN-1:0] a1, a2, m1, m2, sx1, min_v, spec_res;
  logic [XLEN:0]   add_s, sh, diff;
  logic [XLEN-1:0] st_hi, st_lo;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  // Sign-correct and select the final result from {hi,lo}.
  // Multiply: {hi,lo} is the product (word MUL: low word sits in lo's top 32 bits).
  // Divide: hi is the remainder, lo the quotient.
  function automatic logic [XLEN-1:0] finalize(input logic [2:0] op, input logic w,
                                               input logic neg, input logic [XLEN-1:0] hi,
                                               input logic [XLEN-1:0] lo);
    logic [XLEN-1:0] r;
    if (!op[2]) begin
      if (op[1:0] == 2'b00) r = w ? sext32(lo[XLEN-1 -: 32]) : lo;
      else                  r = neg ? (~hi + XLEN'(lo == '0)) : hi;  // high half of -{hi,lo}
    end else begin
      r = op[1] ? hi : lo;
      if (neg) r = -r;
      if (w)   r = sext32(r[31:0]);
    end
    return r;
  endfunction

  // Operand decode: signedness, magnitudes, special divide cases.
  always_comb begin
    is_div = bus.op_i[2];
    wd     = bus.word_i & (is_div | (bus.op_i[1:0] == 2'b00));
    s1s    = is_div ? ~bus.op_i[0] : (bus.op_i[1:0] == 2'b01 || bus.op_i[1:0] == 2'b10);
    s2s    = is_div ? ~bus.op_i[0] : (bus.op_i[1:0] == 2'b01);
    sx1    = sext32(bus.src1_i[31:0]);
    a1     = wd ? (s1s ? sx1 : {{(XLEN-32){1'b0}}, bus.src1_i[31:0]}) : bus.src1_i;
    a2     = wd ? (s2s ? sext32(bus.src2_i[31:0]) : {{(XLEN-32){1'b0}}, bus.src2_i[31:0]})
                : bus.src2_i;
    n1     = s1s & a1[XLEN-1];
    n2     = s2s & a2[XLEN-1];
    m1     = n1 ? -a1 : a1;
    m2     = n2 ? -a2 : a2;
    div0   = (m2 == '0);
    min_v  = wd ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
    ovf    = s1s & (a1 == min_v) & (a2 == '1);
    // REM result follows the dividend; quotient of x/0 must stay all ones.
    neg_f  = is_div ? (bus.op_i[1] ? n1 : ((n1 ^ n2) & ~div0)) : (n1 ^ n2);
    if (bus.op_i[1]) spec_res = div0 ? (wd ? sx1 : bus.src1_i) : '0;
    else             spec_res = div0 ? '1 : min_v;
    start  = bus.valid_i & ~bus.flush_i;
  end

  // One iteration: shift-add multiply step or restoring divide step.
  always_comb begin
    add_s = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    sh    = {hi_q, lo_q[XLEN-1]};
    diff  = sh - {1'b0, b_q};
    if (op_q[2]) begin
      if (!diff[XLEN]) begin
        st_hi = diff[XLEN-1:0];
        st_lo = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        st_hi = sh[XLEN-1:0];
        st_lo = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      st_hi = add_s[XLEN:1];
      st_lo = {add_s[0], lo_q[XLEN-1:1]};
    end
  end

  // Next-state logic; flush overrides acceptance and completion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    b_d     = b_q;
    res_d   = res_q;
    op_d    = op_q;
    word_d  = word_q;
    neg_d   = neg_q;
    case (state_q)
      S_IDLE: if (start) begin
        op_d   = bus.op_i;
        word_d = wd;
        neg_d  = neg_f;
        cnt_d  = wd ? CW'(32) : CW'(XLEN);
        hi_d   = '0;
        // Word divides pre-shift the dividend so 32 steps consume exactly its bits.
        if (is_div) begin
          lo_d = wd ? (m1 << (XLEN-32)) : m1;
          b_d  = m2;
        end else begin
          lo_d = m2;
          b_d  = m1;
        end
        if (FAST_SPECIAL && is_div && (div0 || ovf)) begin
          state_d = S_DONE;
          res_d   = spec_res;
        end else begin
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        hi_d  = st_hi;
        lo_d  = st_lo;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          res_d   = finalize(op_q, word_q, neg_q, st_hi, st_lo);
        end
      end
      S_DONE: if (!bus.ex_hold_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (bus.flush_i) begin
      state_d = S_IDLE;
      res_d   = res_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      res_q   <= '0;
      op_q    <= '0;
      word_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      b_q     <= b_d;
      res_q   <= res_d;
      op_q    <= op_d;
      word_q  <= word_d;
      neg_q   <= neg_d;
    end
  end

  assign bus.stall_o        = ~bus.flush_i &
                              (((state_q == S_IDLE) & bus.valid_i) | (state_q == S_CALC));
  assign bus.result_valid_o = ~bus.flush_i & (state_q == S_DONE);
  assign bus.result_o       = res_q;
  assign bus.busy_o         = (state_q == S_CALC);
endmodule

// File: tb/tb_ex_mul_div_unit.sv
// Directed bench for ex_mul_div_unit: results, latency, hold, flush, reset.
module tb_ex_mul_div_unit;
  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   lat;

  ex_mul_div_unit_if #(.XLEN(64)) bus ();

  ex_mul_div_unit #(.XLEN(64), .FAST_SPECIAL(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive point is 2 time units after the rising edge; checks follow with #1.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Present an op and wait for result_valid_o, counting cycles with stall_o high.
  task automatic run(input logic [2:0] op, input logic w, input logic [63:0] a,
                     input logic [63:0] b, output int nst);
    int it;
    bus.valid_i = 1'b1;
    bus.op_i    = op;
    bus.word_i  = w;
    bus.src1_i  = a;
    bus.src2_i  = b;
    nst = 0;
    it  = 0;
    #1;
    while (bus.result_valid_o !== 1'b1 && it < 200) begin
      if (bus.stall_o === 1'b1) nst++;
      it++;
      tick();
      #1;
    end
    chk("timeout", 64'(it >= 200), 64'd0);
  endtask

  // Retire the instruction and confirm the unit returns to idle without restarting.
  task automatic retire(input string tag);
    bus.valid_i = 1'b0;
    tick();
    #1;
    chk({tag, "_idle_rv"}, 64'(bus.result_valid_o), 64'd0);
    chk({tag, "_idle_busy"}, 64'(bus.busy_o), 64'd0);
  endtask

  initial begin
    rst = 1'b0;
    bus.valid_i = 1'b0; bus.op_i = 3'b000; bus.word_i = 1'b0;
    bus.src1_i = '0; bus.src2_i = '0; bus.ex_hold_i = 1'b0; bus.flush_i = 1'b0;
    repeat (2) tick();
    #1;
    chk("rst_stall", 64'(bus.stall_o), 64'd0);
    chk("rst_rv",    64'(bus.result_valid_o), 64'd0);
    chk("rst_busy",  64'(bus.busy_o), 64'd0);
    chk("rst_res",   bus.result_o, 64'd0);
    tick();
    rst = 1'b1;

    // MUL 7 * -3
    run(3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, lat);
    chk("mul_lat", 64'(lat), 64'd65);
    chk("mul_res", bus.result_o, 64'hFFFF_FFFF_FFFF_FFEB);
    chk("mul_stall_done", 64'(bus.stall_o), 64'd0);
    retire("mul");

    // DIVW overflow special
    run(3'b100, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, lat);
    chk("divw_ovf_lat", 64'(lat), 64'd1);
    chk("divw_ovf_res", bus.result_o, 64'hFFFF_FFFF_8000_0000);
    retire("divw_ovf");

    // REMU by zero
    run(3'b111, 1'b0, 64'd100, 64'd0, lat);
    chk("remu0_lat", 64'(lat), 64'd1);
    chk("remu0_res", bus.result_o, 64'd100);
    retire("remu0");

    // MULHU all ones
    run(3'b011, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, lat);
    chk("mulhu_lat", 64'(lat), 64'd65);
    chk("mulhu_res", bus.result_o, 64'hFFFF_FFFF_FFFF_FFFE);
    retire("mulhu");

    // REM -7 % 2 and DIV -7 / 2
    run(3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, lat);
    chk("rem_res", bus.result_o, 64'hFFFF_FFFF_FFFF_FFFF);
    retire("rem");
    run(3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, lat);
    chk("div_res", bus.result_o, 64'hFFFF_FFFF_FFFF_FFFD);
    retire("div");

    // MULH -2 * 3 and MULHSU -1 * (2^64-1)
    run(3'b001, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, lat);
    chk("mulh_res", bus.result_o, 64'hFFFF_FFFF_FFFF_FFFF);
    retire("mulh");
    run(3'b010, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, lat);
    chk("mulhsu_res", bus.result_o, 64'hFFFF_FFFF_FFFF_FFFF);
    retire("mulhsu");

    // Word ops: MULW ignores upper bits, DIVW -20 / 3
    run(3'b000, 1'b1, 64'h0000_0001_0000_0003, 64'd5, lat);
    chk("mulw_lat", 64'(lat), 64'd33);
    chk("mulw_res", bus.result_o, 64'd15);
    retire("mulw");
    run(3'b100, 1'b1, 64'h0000_0000_FFFF_FFEC, 64'd3, lat);
    chk("divw_lat", 64'(lat), 64'd33);
    chk("divw_res", bus.result_o, 64'hFFFF_FFFF_FFFF_FFFA);
    retire("divw");

    // DIV 100 / 7 with EX held for 3 cycles after completion
    run(3'b100, 1'b0, 64'd100, 64'd7, lat);
    chk("hold_lat", 64'(lat), 64'd65);
    bus.ex_hold_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        bus.ex_hold_i = 1'b0;
        bus.valid_i   = 1'b0;
      end
      #1;
      chk("hold_rv",    64'(bus.result_valid_o), 64'd1);
      chk("hold_res",   bus.result_o, 64'd14);
      chk("hold_stall", 64'(bus.stall_o), 64'd0);
      if (i < 3) tick();
    end
    tick();
    #1;
    chk("hold_after_rv",    64'(bus.result_valid_o), 64'd0);
    chk("hold_after_busy",  64'(bus.busy_o), 64'd0);
    chk("hold_after_stall", 64'(bus.stall_o), 64'd0);

    // Flush DIVU at CALC cycle 10, then MUL 3 * 5
    bus.valid_i = 1'b1; bus.op_i = 3'b101; bus.word_i = 1'b0;
    bus.src1_i = 64'd1000; bus.src2_i = 64'd3;
    repeat (10) tick();
    #1;
    chk("flush_pre_busy",  64'(bus.busy_o), 64'd1);
    chk("flush_pre_stall", 64'(bus.stall_o), 64'd1);
    bus.flush_i = 1'b1;
    #1;
    chk("flush_stall", 64'(bus.stall_o), 64'd0);
    chk("flush_rv",    64'(bus.result_valid_o), 64'd0);
    tick();
    bus.flush_i = 1'b0;
    chk("flush_post_busy", 64'(bus.busy_o), 64'd0);
    run(3'b000, 1'b0, 64'd3, 64'd5, lat);
    chk("post_flush_lat", 64'(lat), 64'd65);
    chk("post_flush_res", bus.result_o, 64'd15);
    retire("post_flush");

    // Reset at CALC cycle 20, then a clean DIVU
    bus.valid_i = 1'b1; bus.op_i = 3'b101; bus.word_i = 1'b0;
    bus.src1_i = 64'd1000; bus.src2_i = 64'd10;
    repeat (20) tick();
    rst = 1'b0;
    bus.valid_i = 1'b0;
    tick();
    #1;
    chk("mid_rst_stall", 64'(bus.stall_o), 64'd0);
    chk("mid_rst_rv",    64'(bus.result_valid_o), 64'd0);
    chk("mid_rst_busy",  64'(bus.busy_o), 64'd0);
    chk("mid_rst_res",   bus.result_o, 64'd0);
    tick();
    rst = 1'b1;
    run(3'b101, 1'b0, 64'd1000, 64'd10, lat);
    chk("post_rst_lat", 64'(lat), 64'd65);
    chk("post_rst_res", bus.result_o, 64'd100);
    retire("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ex_mul_div_unit.md
Name: ex_mul_div_unit

Overview:
- Iterative RV64M multiply/divide unit in the EX stage.
- Its `stall_o` drives the pipeline controller's mul/div stall request, `alu_mul_div_valid_ex_i`. While it is asserted, PC, Pre_IF and IF_ID hold and EX_MEM is flushed with a bubble.
- It accepts one M-extension instruction from the ID_EX register and computes it over multiple cycles. It presents the result for one cycle, or longer while EX is held by a higher-priority stall. It aborts cleanly on flush.

Parameters:
- XLEN, 64, datapath width; `word_i` ops use the low 32 bits.
- FAST_SPECIAL, 1, when 1, divide-by-zero and signed overflow complete without iterating.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset.
- valid_i  input  1  EX holds a valid M-extension instruction.
- op_i  input  3  encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- word_i  input  1  W-variant: operate on [31:0] and sign-extend the 32-bit result; ignored for MULH/MULHSU/MULHU.
- src1_i  input  XLEN  rs1 operand (dividend / multiplicand).
- src2_i  input  XLEN  rs2 operand (divisor / multiplier).
- ex_hold_i  input  1  EX is held by another stall source (mem/IF/trap); the instruction stays in EX.
- flush_i  input  1  ID_EX/EX flush from the controller; abort the current op.
- stall_o  output  1  request stall of the upstream stages.
- result_o  output  XLEN  final result, valid when `result_valid_o`=1.
- result_valid_o  output  1  result ready for the EX_MEM write this cycle.
- busy_o  output  1  state is CALC.

Behaviour:
- Reset (`rst`=0 at an edge) forces IDLE and clears all internal registers. Outputs after reset: `stall_o`=0 (given `valid_i`=0), `result_o`=0, `result_valid_o`=0, `busy_o`=0. Reset in any state, including mid-CALC, aborts with no result.
- States:
  - IDLE: `stall_o` = `valid_i` & ~`flush_i` (combinational, same cycle the instruction arrives).
  - IDLE → CALC when `valid_i` & ~`flush_i`. On that edge: latch magnitudes (signed ops take absolute values), latch result-sign flags, set counter N=32 if `word_i` else XLEN, clear the accumulator.
  - IDLE → DONE directly for special cases when FAST_SPECIAL=1:
    - Divisor 0: quotient = all ones; remainder = dividend (word: sign-extended low 32).
    - Signed overflow (MIN / -1): quotient = MIN; remainder = 0.
  - CALC: one bit per cycle. Multiply is shift-add into a 2·XLEN product. Divide is restoring: shift remainder, subtract, set quotient bit.
    - Counter decrements each cycle. `stall_o`=1, `busy_o`=1.
    - CALC → DONE when the counter reaches 0.
  - DONE: apply sign correction and select the result:
    - MUL: low half.
    - MULH*: high half.
    - DIV*: quotient.
    - REM*: remainder; its sign follows the dividend.
    - `word_i`: sign-extend bit 31.
  - DONE outputs: register `result_o`; `result_valid_o`=1; `stall_o`=0.
  - DONE → IDLE when ~`ex_hold_i`. While `ex_hold_i`=1, stay in DONE holding `result_o` and `result_valid_o`, so the held instruction is not restarted.
- Latency: accept at edge 0, then N CALC cycles, so `result_valid_o` rises N+1 cycles after acceptance. That is 65 cycles for 64-bit ops and 33 for word ops. Special cases take 1 cycle.
- `flush_i`=1 in any state: next state IDLE; `result_valid_o` and `stall_o` deasserted the same cycle (combinational mask). The flush has priority over acceptance and completion on the same edge.
- `valid_i` dropping in CALC without `flush_i` is illegal and need not be handled; the verifier asserts it never happens.
- MULHSU: only src1 is treated as signed. MULHU, DIVU and REMU are fully unsigned.
- In IDLE, `result_o` keeps its last value; consumers must qualify it with `result_valid_o`.

Test Plan:
- MUL src1=7, src2=-3, `word_i`=0 → `stall_o` high for 65 cycles, then `result_valid_o`=1 for 1 cycle with `result_o`=0xFFFF_FFFF_FFFF_FFEB; `stall_o`=0 that cycle.
- DIVW src1=0x0000_0000_8000_0000, src2=0xFFFF_FFFF_FFFF_FFFF → overflow special, 1 cycle, `result_o`=0xFFFF_FFFF_8000_0000. REMU src1=100, src2=0 → `result_o`=100.
- MULHU src1=src2=0xFFFF_FFFF_FFFF_FFFF → `result_o`=0xFFFF_FFFF_FFFF_FFFE after 65 cycles. REM src1=-7, src2=2 → `result_o`=-1.
- DIV src1=100, src2=7, with `ex_hold_i`=1 for 3 cycles after DONE → `result_valid_o` held 4 cycles at 14, no restart, then IDLE.
- Start DIVU, assert `flush_i` at CALC cycle 10 → `stall_o`=0 and no `result_valid_o`. A new MUL 3×5 the next cycle gives 15 with full latency.
- Pull `rst` low at CALC cycle 20 → all outputs 0 on the following cycle; a subsequent op completes correctly.
